// File: rtl/daa_booth_sequencer_if.sv
// Operand-pair handshake between the host-side source (master) and the
// Booth sequencer (slave).
interface daa_booth_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_act;
  logic [7:0] op_wgt;

  modport master (output op_valid, output op_act, output op_wgt, input op_ready);
  modport slave  (input op_valid, input op_act, input op_wgt, output op_ready);
endinterface

// File: rtl/daa_booth_sequencer.sv
// Booth radix-4 dot-product sequencer: buffers operand pairs, replays them
// digit-major to the MAC datapath. Optional feature macro: DAA_SEQ_SIGNED_EN.
module daa_booth_sequencer #(
  parameter int DEPTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  vec_len,
  input  logic                        job_signed,
  daa_booth_sequencer_if.slave        opb,
  output logic [3:0]                  dp_inpe,
  output logic [2:0]                  dp_w,
  output logic                        dp_nep,
  output logic [3:0]                  dp_epcount,
  output logic                        dp_clear,
  output logic                        dp_sign_ex_en,
  output logic                        busy,
  output logic                        done
);
  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              KW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]      DEPTH_L = 4'(DEPTH);
  localparam logic [KW-1:0]   LAST_K  = KW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    n_len;
  logic [3:0]    ld_cnt;
  logic [IW-1:0] elem;
  logic [KW-1:0] digit;
  logic          drain_cnt;
  logic          op_ready_q;

  logic [3:0]    act_mem [DEPTH];
  logic [7:0]    wgt_mem [DEPTH];

  logic          accept;
  logic          last_load;
  logic          last_elem;
  logic [3:0]    clamped_len;
  logic          job_sign_sel;

  logic [IW-1:0] sel_elem;
  logic [KW-1:0] sel_digit;
  logic [3:0]    sel_act;
  logic [7:0]    sel_wgt;
  logic [8:0]    wgt_ext;
  logic [3:0]    trip_lsb;
  logic [2:0]    sel_trip;
  logic          sel_nep;

  assign opb.op_ready = op_ready_q;
  assign accept       = (state == S_LOAD) && opb.op_valid && op_ready_q;
  assign last_load    = (ld_cnt == n_len - 4'd1);
  assign last_elem    = (4'(elem) == n_len - 4'd1);
  assign clamped_len  = (vec_len > DEPTH_L) ? DEPTH_L : vec_len;

`ifdef DAA_SEQ_SIGNED_EN
  assign job_sign_sel = job_signed;
`else
  logic job_signed_unused;
  assign job_signed_unused = job_signed;
  assign job_sign_sel      = 1'b0;
`endif

  // Next element/digit to present. The LOAD->RUN step presents entry 0, which
  // for a one-element job is still on the operand bus in that same cycle.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    sel_elem  = '0;
    sel_digit = '0;
    if (state == S_RUN) begin
      if (last_elem) begin
        sel_digit = digit + KW'(1);
      end else begin
        sel_elem  = elem + IW'(1);
        sel_digit = digit;
      end
    end
    if ((state == S_LOAD) && (n_len == 4'd1)) begin
      sel_act = opb.op_act;
      sel_wgt = opb.op_wgt;
    end else begin
      sel_act = act_mem[sel_elem];
      sel_wgt = wgt_mem[sel_elem];
    end
    // Triplet {w[2k+1], w[2k], w[2k-1]} with an implicit zero below bit 0.
    wgt_ext  = {sel_wgt, 1'b0};
    trip_lsb = 4'({sel_digit, 1'b0});
    sel_trip = wgt_ext[trip_lsb +: 3];
    sel_nep  = (4'(sel_elem) == n_len - 4'd1);
  end

  // NOTE: the operand buffer is deliberately not reset; every entry is written
  // during LOAD before RUN can read it.
  always_ff @(posedge clk) begin
    if (accept) begin
      act_mem[ld_cnt[IW-1:0]] <= opb.op_act;
      wgt_mem[ld_cnt[IW-1:0]] <= opb.op_wgt;
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      n_len         <= '0;
      ld_cnt        <= '0;
      elem          <= '0;
      digit         <= '0;
      drain_cnt     <= 1'b0;
      op_ready_q    <= 1'b0;
      dp_inpe       <= '0;
      dp_w          <= '0;
      dp_nep        <= 1'b0;
      dp_epcount    <= '0;
      dp_clear      <= 1'b0;
      dp_sign_ex_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Strobes and datapath operands fall back to the zero partial product.
      dp_clear   <= 1'b0;
      done       <= 1'b0;
      dp_inpe    <= '0;
      dp_w       <= '0;
      dp_nep     <= 1'b0;
      dp_epcount <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_CLEAR;
            n_len         <= clamped_len;
            busy          <= 1'b1;
            dp_clear      <= 1'b1;
            dp_sign_ex_en <= job_sign_sel;
          end
        end

        S_CLEAR: begin
          ld_cnt <= '0;
          if (n_len == 4'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state      <= S_LOAD;
            op_ready_q <= 1'b1;
          end
        end

        S_LOAD: begin
          if (accept) begin
            ld_cnt <= ld_cnt + 4'd1;
            if (last_load) begin
              state      <= S_RUN;
              op_ready_q <= 1'b0;
              elem       <= '0;
              digit      <= '0;
              dp_inpe    <= sel_act;
              dp_w       <= sel_trip;
              dp_nep     <= sel_nep;
              dp_epcount <= sel_nep ? 4'(sel_digit) : 4'd0;
            end
          end
        end

        S_RUN: begin
          if (last_elem && (digit == LAST_K)) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
            elem      <= '0;
            digit     <= '0;
          end else begin
            elem       <= sel_elem;
            digit      <= sel_digit;
            dp_inpe    <= sel_act;
            dp_w       <= sel_trip;
            dp_nep     <= sel_nep;
            dp_epcount <= sel_nep ? 4'(sel_digit) : 4'd0;
          end
        end

        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          dp_sign_ex_en <= 1'b0;
        end

        default: begin
          state         <= S_IDLE;
          busy          <= 1'b0;
          op_ready_q    <= 1'b0;
          dp_sign_ex_en <= 1'b0;
        end
      endcase
    end
  end
endmodule
